// File: rtl/jbus_ctl_pkg.sv
// Shared types and default sizing for the jbus register-transfer controller.
// JBUS_CTL_RR_EN (see jbus_ctl.sv) selects round-robin arbitration.
package jbus_ctl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ENA  = 2'd1,
        ST_SET  = 2'd2,
        ST_ACK  = 2'd3
    } state_t;

    // Index width that stays at least one bit for degenerate sizes.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int NREQ_DEF = 4;
    localparam int NREG_DEF = 4;
    localparam int SELW_DEF = idx_width(NREG_DEF);

endpackage

// File: rtl/jbus_ctl_if.sv
// Requester/register-bus bundle between the requesters and jbus_ctl.
// slave is the controller side, master the requester/register-file side.
interface jbus_ctl_if
    import jbus_ctl_pkg::*;
#(
    parameter int NREQ = NREQ_DEF,
    parameter int NREG = NREG_DEF
);
    localparam int SELW = idx_width(NREG);
    localparam int IDW  = idx_width(NREQ);

    logic [NREQ-1:0]      req;
    logic [NREQ*SELW-1:0] src;
    logic [NREQ*SELW-1:0] dst;
    logic [NREQ-1:0]      ack;
    logic                 busy;
    logic [IDW-1:0]       gnt_id;
    logic [NREG-1:0]      reg_we;
    logic [NREG-1:0]      reg_ws;

    modport slave (
        input  req, src, dst,
        output ack, busy, gnt_id, reg_we, reg_ws
    );

    modport master (
        output req, src, dst,
        input  ack, busy, gnt_id, reg_we, reg_ws
    );

endinterface

// File: rtl/jbus_arb.sv
// Combinational arbiter: first requester found searching upward from ptr
// (wrapping) wins. With ptr tied to zero this is lowest-index priority.
module jbus_arb #(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  ptr,
    output logic [IDW-1:0]  winner,
    output logic            valid
);

    always_comb begin
        int idx;
        idx    = 0;
        winner = '0;
        valid  = 1'b0;
        // Scan from the far end back toward ptr so the last hit is the nearest.
        for (int k = NREQ - 1; k >= 0; k--) begin
            idx = (int'(ptr) + k) % NREQ;
            if (req[idx]) begin
                winner = IDW'(idx);
                valid  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/jdecoder.sv
// Gate-level binary-to-one-hot decoder: y[k] is the AND of the input bits
// matching the binary pattern of k (true or inverted literal per bit).
module jdecoder #(
    parameter int N  = 2,
    parameter int N2 = 4
) (
    input  logic [N-1:0]  a,
    output logic [N2-1:0] y
);

    genvar gi, bi;
    for (gi = 0; gi < N2; gi++) begin : g_out
        logic [N-1:0] term;
        for (bi = 0; bi < N; bi++) begin : g_bit
            if (((gi >> bi) & 1) == 1) begin : g_true
                assign term[bi] = a[bi];
            end else begin : g_inv
                assign term[bi] = ~a[bi];
            end
        end
        assign y[gi] = &term;
    end

endmodule

// File: rtl/jbus_ctl.sv
// Register-bus transfer controller: arbitrates requesters and sequences
// ENA/SET/ACK. Define JBUS_CTL_RR_EN for round-robin, else fixed priority.
module jbus_ctl
    import jbus_ctl_pkg::*;
#(
    parameter int NREQ = NREQ_DEF,
    parameter int NREG = NREG_DEF
) (
    input  logic          clk,
    input  logic          reset,
    jbus_ctl_if.slave     bus
);

    localparam int SELW = idx_width(NREG);
    localparam int IDW  = idx_width(NREQ);

    state_t          state_reg, state_next;
    logic [IDW-1:0]  win_reg, win_next;
    logic [SELW-1:0] src_reg, src_next;
    logic [SELW-1:0] dst_reg, dst_next;

    logic [NREQ-1:0] ack_reg, ack_next;
    logic            busy_reg, busy_next;
    logic [NREG-1:0] we_reg, we_next;
    logic [NREG-1:0] ws_reg, ws_next;

    logic [IDW-1:0]  ptr;
    logic [IDW-1:0]  arb_win;
    logic            arb_valid;
    logic [NREG-1:0] src_oh, dst_oh;

    jbus_arb #(.NREQ(NREQ), .IDW(IDW)) u_arb (
        .req    (bus.req),
        .ptr    (ptr),
        .winner (arb_win),
        .valid  (arb_valid)
    );

`ifdef JBUS_CTL_RR_EN
    logic [IDW-1:0] ptr_reg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            ptr_reg <= '0;
        else if (state_reg == ST_IDLE && arb_valid)
            ptr_reg <= (arb_win == IDW'(NREQ - 1)) ? '0 : arb_win + 1'b1;
    end

    assign ptr = ptr_reg;
`else
    assign ptr = '0;
`endif

    // Transfer parameters are captured only in IDLE; later input changes are ignored.
    always_comb begin
        state_next = state_reg;
        win_next   = win_reg;
        src_next   = src_reg;
        dst_next   = dst_reg;
        case (state_reg)
            ST_IDLE: begin
                if (arb_valid) begin
                    win_next   = arb_win;
                    src_next   = bus.src[arb_win*SELW +: SELW];
                    dst_next   = bus.dst[arb_win*SELW +: SELW];
                    state_next = (src_next == dst_next) ? ST_ACK : ST_ENA;
                end
            end
            ST_ENA:  state_next = ST_SET;
            ST_SET:  state_next = ST_ACK;
            default: state_next = ST_IDLE;
        endcase
    end

    jdecoder #(.N(SELW), .N2(NREG)) u_dec_src (.a(src_next), .y(src_oh));
    jdecoder #(.N(SELW), .N2(NREG)) u_dec_dst (.a(dst_next), .y(dst_oh));

    // Outputs are decoded from the next state so they register alongside it.
    always_comb begin
        busy_next = (state_next != ST_IDLE);
        we_next   = (state_next == ST_ENA || state_next == ST_SET) ? src_oh : '0;
        ws_next   = (state_next == ST_SET) ? dst_oh : '0;
        ack_next  = '0;
        if (state_next == ST_ACK)
            ack_next[win_next] = 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= ST_IDLE;
            win_reg   <= '0;
            src_reg   <= '0;
            dst_reg   <= '0;
            ack_reg   <= '0;
            busy_reg  <= 1'b0;
            we_reg    <= '0;
            ws_reg    <= '0;
        end else begin
            state_reg <= state_next;
            win_reg   <= win_next;
            src_reg   <= src_next;
            dst_reg   <= dst_next;
            ack_reg   <= ack_next;
            busy_reg  <= busy_next;
            we_reg    <= we_next;
            ws_reg    <= ws_next;
        end
    end

    assign bus.ack    = ack_reg;
    assign bus.busy   = busy_reg;
    assign bus.gnt_id = win_reg;
    assign bus.reg_we = we_reg;
    assign bus.reg_ws = ws_reg;

endmodule

// File: tb/tb_jbus_ctl.sv
// Scoreboard bench for jbus_ctl: stimulus queues expected bus activity,
// a negedge monitor pops and compares whenever the controller drives anything.
module tb_jbus_ctl;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    jbus_ctl_if #(.NREQ(4), .NREG(4)) bus ();

    jbus_ctl #(.NREQ(4), .NREG(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        int         cyc;
        logic [3:0] we;
        logic [3:0] ws;
        logic [3:0] ack;
        logic [1:0] gnt;
    } exp_t;

    exp_t exp_q[$];
    int   cyc      = 0;
    int   n_checks = 0;
    int   n_fail   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: every non-idle bus cycle must match the head of the queue.
    always @(negedge clk) begin
        exp_t e;
        if (!reset && (bus.reg_we != 4'd0 || bus.reg_ws != 4'd0 || bus.ack != 4'd0)) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_output cyc=%0d actual we=%b ws=%b ack=%b gnt=%0d required none",
                         cyc, bus.reg_we, bus.reg_ws, bus.ack, bus.gnt_id);
            end else begin
                e = exp_q.pop_front();
                if (cyc != e.cyc || bus.reg_we !== e.we || bus.reg_ws !== e.ws ||
                    bus.ack !== e.ack || bus.gnt_id !== e.gnt) begin
                    n_fail++;
                    $display("FAIL bus_cycle actual cyc=%0d we=%b ws=%b ack=%b gnt=%0d required cyc=%0d we=%b ws=%b ack=%b gnt=%0d",
                             cyc, bus.reg_we, bus.reg_ws, bus.ack, bus.gnt_id,
                             e.cyc, e.we, e.ws, e.ack, e.gnt);
                end else begin
                    $display("xfer cyc=%0d we=%b ws=%b ack=%b gnt=%0d ok",
                             cyc, bus.reg_we, bus.reg_ws, bus.ack, bus.gnt_id);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req_v);
        n_checks++;
        if (act !== req_v) begin
            n_fail++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req_v);
        end
    endtask

    // Expected bus cycles of one transfer sampled at the edge that makes cyc == smp.
    task automatic push_xfer(input int w, input int s, input int d, input int smp, input bit aborted);
        logic [3:0] s_oh, d_oh, a_oh;
        s_oh = 4'b0001 << s;
        d_oh = 4'b0001 << d;
        a_oh = 4'b0001 << w;
        if (s == d) begin
            exp_q.push_back('{cyc: smp, we: 4'b0, ws: 4'b0, ack: a_oh, gnt: 2'(w)});
        end else begin
            exp_q.push_back('{cyc: smp,     we: s_oh, ws: 4'b0, ack: 4'b0, gnt: 2'(w)});
            exp_q.push_back('{cyc: smp + 1, we: s_oh, ws: d_oh, ack: 4'b0, gnt: 2'(w)});
            if (!aborted)
                exp_q.push_back('{cyc: smp + 2, we: 4'b0, ws: 4'b0, ack: a_oh, gnt: 2'(w)});
        end
    endtask

    task automatic drive(input int i, input logic [1:0] s, input logic [1:0] d);
        bus.src[i*2 +: 2] = s;
        bus.dst[i*2 +: 2] = d;
        bus.req[i]        = 1'b1;
    endtask

    task automatic wait_idle(input string name);
        int t;
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while ((bus.busy || exp_q.size() != 0) && t < 60);
        if (t >= 60) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s_timeout actual busy=%0d pending=%0d required idle", name, bus.busy, exp_q.size());
        end
        chk({name, "_idle_busy"}, 32'(bus.busy), 32'd0);
    endtask

    task automatic wait_cyc(input int target);
        int t;
        t = 0;
        while (cyc < target && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (cyc < target) begin
            n_checks++;
            n_fail++;
            $display("FAIL wait_cyc actual=%0d required=%0d", cyc, target);
        end
    endtask

    task automatic check_zero(input string name);
        chk({name, "_ack"},  32'(bus.ack),    32'd0);
        chk({name, "_busy"}, 32'(bus.busy),   32'd0);
        chk({name, "_gnt"},  32'(bus.gnt_id), 32'd0);
        chk({name, "_we"},   32'(bus.reg_we), 32'd0);
        chk({name, "_ws"},   32'(bus.reg_ws), 32'd0);
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        bus.req = '0;
        bus.src = '0;
        bus.dst = '0;
        repeat (3) @(negedge clk);
        check_zero("reset_state");
        reset = 1'b0;

        // Single transfer: requester 1 moves reg2 -> reg0.
        @(negedge clk);
        k = cyc;
        drive(1, 2'd2, 2'd0);
        push_xfer(1, 2, 0, k + 1, 1'b0);
        @(negedge clk);
        bus.req = '0;
        wait_idle("single");

        // src == dst: straight to ACK, no register strobes.
        @(negedge clk);
        k = cyc;
        drive(0, 2'd3, 2'd3);
        push_xfer(0, 3, 3, k + 1, 1'b0);
        @(negedge clk);
        bus.req = '0;
        wait_idle("same_reg");

        pulse_reset();

`ifdef JBUS_CTL_RR_EN
        // All four held: grants rotate 0,1,2,3,0 one transfer every 4 cycles.
        @(negedge clk);
        k = cyc;
        for (int i = 0; i < 4; i++) drive(i, 2'(i), 2'((i + 1) % 4));
        for (int j = 0; j < 5; j++) push_xfer(j % 4, j % 4, (j + 1) % 4, k + 1 + 4*j, 1'b0);
        wait_cyc(k + 17);
        bus.req = '0;
        wait_idle("rr_contention");
`else
        // Requesters 1 and 2 held: lowest index keeps winning.
        @(negedge clk);
        k = cyc;
        drive(1, 2'd1, 2'd2);
        drive(2, 2'd3, 2'd0);
        for (int j = 0; j < 3; j++) push_xfer(1, 1, 2, k + 1 + 4*j, 1'b0);
        wait_cyc(k + 9);
        bus.req = '0;
        wait_idle("fixed_contention");
`endif

        // Reset during SET aborts the transfer; no ack follows.
        @(negedge clk);
        k = cyc;
        drive(1, 2'd0, 2'd3);
        push_xfer(1, 0, 3, k + 1, 1'b1);
        @(negedge clk);
        bus.req = '0;
        @(negedge clk);
        #2 reset = 1'b1;
        #1 check_zero("abort_reset");
        @(negedge clk);
        reset = 1'b0;
        repeat (6) @(negedge clk);
        chk("abort_no_pending", 32'(exp_q.size()), 32'd0);

        // After the abort the next grant goes to requester 0.
        @(negedge clk);
        k = cyc;
        drive(0, 2'd2, 2'd1);
        drive(2, 2'd1, 2'd3);
        push_xfer(0, 2, 1, k + 1, 1'b0);
        @(negedge clk);
        bus.req = '0;
        wait_idle("post_abort");

        // Inputs change during ENA: latched indices still used, ack still sent.
        @(negedge clk);
        k = cyc;
        drive(3, 2'd1, 2'd2);
        push_xfer(3, 1, 2, k + 1, 1'b0);
        @(negedge clk);
        bus.src[6 +: 2] = 2'd0;
        bus.dst[6 +: 2] = 2'd3;
        bus.req = '0;
        wait_idle("mid_change");

        repeat (4) @(negedge clk);
        chk("final_queue_empty", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/jbus_ctl.md
JBUS_CTL -- requirements
Module: jbus_ctl

Interface
REQ-001 Parameter NREQ, default 4: number of requesters sharing the register bus.
REQ-002 Parameter NREG, default 4: number of registers on the bus; SELW = log2(NREG), so 2 by default.
REQ-003 clk  in  1  single clock; all state changes on its rising edge.
REQ-004 reset  in  1  asynchronous, active-high reset.
REQ-005 req  in  NREQ  per-requester transfer request, level-sensitive.
REQ-006 src  in  NREQ*SELW  packed source register index; requester i uses slice [i*SELW +: SELW].
REQ-007 dst  in  NREQ*SELW  packed destination register index; same slicing as src.
REQ-008 ack  out  NREQ  one-cycle completion pulse per requester.
REQ-009 busy  out  1  high in every state except IDLE.
REQ-010 gnt_id  out  clog2(NREQ)  index of the requester currently being served.
REQ-011 reg_we  out  NREG  one-hot register enable that drives the register onto the bus.
REQ-012 reg_ws  out  NREG  one-hot register set that captures the bus into a register.

Function
REQ-013 FSM states SHALL be IDLE, ENA, SET and ACK.
REQ-014 IDLE SHALL sample req; if any bit is set, the arbiter picks winner w, and the block latches w, src[w] and dst[w].
- Next state is ENA, or ACK when src[w]==dst[w].
REQ-015 ENA SHALL assert only reg_we[src] for exactly one cycle, so the bus settles; next state is SET.
REQ-016 SET SHALL assert reg_we[src] and reg_ws[dst] for exactly one cycle; the destination captures at the rising edge that ends SET; next state is ACK.
REQ-017 ACK SHALL pulse ack[w] for one cycle, with reg_we and reg_ws both zero; next state is IDLE.
REQ-018 Latency SHALL be 4 cycles from sampling req to the ack pulse for a normal transfer, and 2 cycles for a src==dst transfer.
REQ-019 reg_we and reg_ws SHALL never have more than one bit set, and reg_ws SHALL never be asserted without reg_we.
REQ-020 Changes to req, src or dst after the grant SHALL be ignored until the next IDLE.
- A req dropped mid-transfer still completes and is still acked.
REQ-021 A requester that holds req through its ack SHALL be re-arbitrated as a new request, with no special priority.
REQ-022 All outputs SHALL be registered, with no combinational path from inputs to outputs.

Reset
REQ-023 reset SHALL force, asynchronously:
- state to IDLE;
- ack, busy, gnt_id, reg_we and reg_ws to 0;
- the round-robin pointer to 0.
REQ-024 A reset during ENA or SET SHALL abort the transfer: no ack is issued and the destination register is left unset.

Configuration
REQ-025 With JBUS_CTL_RR_EN defined, arbitration SHALL be round-robin.
- The search starts at the pointer.
- After granting w, the pointer becomes (w+1) mod NREQ.
REQ-026 Without JBUS_CTL_RR_EN, arbitration SHALL be fixed priority, where the lowest index wins; the pointer logic is omitted.

Structure
REQ-027 Package jbus_ctl_pkg SHALL hold the FSM state enum and the default NREQ, NREG and SELW constants.
REQ-028 The arbiter SHALL be the sub-module jbus_arb (inputs req and pointer; output winner index and valid).
REQ-029 Index-to-one-hot conversion SHALL reuse the existing gate-level decoder jdecoder with N=SELW and N2=NREG.

Verification
REQ-030 Single transfer: req[1]=1, src1=2, dst1=0.
- Expected: reg_we=0100 for 2 cycles, reg_ws=0001 in the second of them, ack[1] in cycle 4, then IDLE.
REQ-031 src==dst: req[0]=1, src0=dst0=3.
- Expected: ack[0] 2 cycles after sampling, with reg_we and reg_ws zero throughout.
REQ-032 Contention, with JBUS_CTL_RR_EN defined: req=1111 held.
- Expected: grant order 0,1,2,3,0; each ack spaced 4 cycles apart.
REQ-033 Contention, without JBUS_CTL_RR_EN: req=0110 held.
- Expected: requester 1 is always granted and requester 2 is starved.
REQ-034 Reset asserted in the SET cycle.
- Expected: all outputs 0 immediately, no ack, and the next grant goes to requester 0.
REQ-035 Mid-transfer change: alter src/dst and drop req during ENA.
- Expected: the originally latched transfer completes with the original indices, and ack is still pulsed.
